// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between ALU and load unit, with a pending-write scoreboard
// that blocks WAW issue and flags RAW hazards for the issuing instruction.
module regfile_wb_arbiter #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            hazard,

    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,

    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Readies are combinational from valid, the scoreboard and the starvation count.

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0]   starve_cnt;
    logic            armed;
    logic            alu_starved;
    logic            wb_fire;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy_next;

    always_comb begin
        alu_starved = (starve_cnt == CW'(MAX_WAIT));
        // armed is low only in the first cycle after reset release, so no
        // grant can complete and no write can land on that edge.
        alu_ready   = armed && alu_valid && (!lsu_valid || alu_starved);
        lsu_ready   = armed && lsu_valid && !(alu_valid && alu_starved);

        iss_ready   = !((iss_rd != 5'd0) && busy[iss_rd]);
        hazard      = ((iss_rs1 != 5'd0) && busy[iss_rs1]) ||
                      ((iss_rs2 != 5'd0) && busy[iss_rs2]);

        wb_fire     = alu_ready || lsu_ready;
        wb_rd       = alu_ready ? alu_rd   : lsu_rd;
        wb_data     = alu_ready ? alu_data : lsu_data;

        // Clear first so a same-edge reservation of that register wins.
        busy_next = busy;
        if (rf_we)
            busy_next[rf_waddr] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != 5'd0))
            busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            busy       <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            armed <= 1'b1;
            busy  <= busy_next;

            rf_we <= wb_fire && (wb_rd != 5'd0);
            if (wb_fire && (wb_rd != 5'd0)) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end

            if (alu_ready)
                starve_cnt <= '0;
            else if (armed && alu_valid && !alu_starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
